// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the complete-stage CDB arbiter (system defines for FU/CDB counts).
package cdb_arbiter_pkg;

    localparam int NUM_ALU  = 3;
    localparam int NUM_MULT = 2;
    localparam int NUM_FU   = NUM_ALU + NUM_MULT;
    localparam int NUM_CDB  = 2;
    localparam int XLEN     = 64;
    localparam int PR_IDX_W = 6;
    localparam int RR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic                valid;
        logic [PR_IDX_W-1:0] T_idx;
        logic [XLEN-1:0]     value;
    } FU_RESULT_ENTRY_t;

    typedef struct packed {
        logic                valid;
        logic [PR_IDX_W-1:0] T_idx;
        logic [XLEN-1:0]     value;
    } CDB_PACKET_t;

    function automatic logic [RR_W-1:0] onehot_to_idx(input logic [NUM_FU-1:0] oh);
        logic [RR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (oh[i]) idx = RR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: one-hot of the first request at or after the start pointer, wrapping.
import cdb_arbiter_pkg::*;

module rr_picker #(
    parameter int N     = NUM_FU,
    parameter int PTR_W = RR_W
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one result slot per FU, round-robin broadcast onto NUM_CDB lanes.
// Optional same-cycle bypass of empty-slot results into leftover lanes under CDB_BYPASS_EN.
import cdb_arbiter_pkg::*;

module cdb_arbiter (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_FU-1:0]            fu_done,
    input  logic [NUM_FU*PR_IDX_W-1:0]   fu_T_idx,
    input  logic [NUM_FU*XLEN-1:0]       fu_result,
    input  logic                         rollback,
    output logic [NUM_FU-1:0]            full_hazard,
    output logic [NUM_CDB-1:0]           cdb_valid,
    output logic [NUM_CDB*PR_IDX_W-1:0]  cdb_T_idx,
    output logic [NUM_CDB*XLEN-1:0]      cdb_value
);

    // Handshake: FU i offers a result with fu_done[i]; it is taken at the clock edge only when
    // full_hazard[i]=0 (and no rollback), otherwise the FU must hold and re-present it.

    FU_RESULT_ENTRY_t slot_q [NUM_FU];
    FU_RESULT_ENTRY_t slot_d [NUM_FU];
    FU_RESULT_ENTRY_t fu_in  [NUM_FU];
    CDB_PACKET_t      lane_pkt [NUM_CDB];

    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]   last_idx;
    logic [NUM_FU-1:0] slot_valid;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] lane_req [NUM_CDB];
    logic [NUM_FU-1:0] lane_gnt [NUM_CDB];
    logic [NUM_FU-1:0] bypass_gnt;
    logic [NUM_FU-1:0] bypass_take;
    logic              bypass_fire;
    logic              bypass_placed;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_in[i].valid = fu_done[i];
            fu_in[i].T_idx = fu_T_idx[i*PR_IDX_W +: PR_IDX_W];
            fu_in[i].value = fu_result[i*XLEN +: XLEN];
            slot_valid[i]  = slot_q[i].valid;
        end
    end

    // Each lane picks the next valid slot in scan order with earlier lanes' grants masked out.
    assign lane_req[0] = slot_valid;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        if (k > 0) begin : g_mask
            assign lane_req[k] = lane_req[k-1] & ~lane_gnt[k-1];
        end
        rr_picker #(.N(NUM_FU), .PTR_W(RR_W)) u_pick (
            .req_i (lane_req[k]),
            .ptr_i (rr_ptr_q),
            .gnt_o (lane_gnt[k])
        );
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < NUM_CDB; k++) grant = grant | lane_gnt[k];
    end

    assign full_hazard = slot_valid & ~grant;

`ifdef CDB_BYPASS_EN
    rr_picker #(.N(NUM_FU), .PTR_W(RR_W)) u_bypass_pick (
        .req_i (fu_done & ~slot_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (bypass_gnt)
    );
    // Slot grants fill lanes from lane 0, so a free lane exists iff the last lane is unused.
    assign bypass_fire = (|bypass_gnt) & ~(|lane_gnt[NUM_CDB-1]) & ~rollback & ~reset;
`else
    assign bypass_gnt  = '0;
    assign bypass_fire = 1'b0;
`endif

    assign bypass_take = bypass_fire ? bypass_gnt : '0;

    always_comb begin
        bypass_placed = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_pkt[k] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (lane_gnt[k][i]) begin
                    lane_pkt[k].valid = 1'b1;
                    lane_pkt[k].T_idx = slot_q[i].T_idx;
                    lane_pkt[k].value = slot_q[i].value;
                end
            end
            if (!lane_pkt[k].valid && bypass_fire && !bypass_placed) begin
                bypass_placed = 1'b1;
                for (int i = 0; i < NUM_FU; i++) begin
                    if (bypass_gnt[i]) begin
                        lane_pkt[k].valid = 1'b1;
                        lane_pkt[k].T_idx = fu_in[i].T_idx;
                        lane_pkt[k].value = fu_in[i].value;
                    end
                end
            end
            if (rollback || reset) lane_pkt[k] = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_valid[k]                      = lane_pkt[k].valid;
            cdb_T_idx[k*PR_IDX_W +: PR_IDX_W] = lane_pkt[k].T_idx;
            cdb_value[k*XLEN +: XLEN]         = lane_pkt[k].value;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            slot_d[i] = slot_q[i];
            if (rollback) begin
                slot_d[i] = '0;
            end else if (fu_in[i].valid && !full_hazard[i] && !bypass_take[i]) begin
                slot_d[i] = fu_in[i];
            end else if (grant[i]) begin
                slot_d[i] = '0;
            end
        end
    end

    always_comb begin
        last_idx = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (|lane_gnt[k]) last_idx = onehot_to_idx(lane_gnt[k]);
        end
        rr_ptr_d = rr_ptr_q;
        if (!rollback && (|grant)) begin
            rr_ptr_d = (last_idx == RR_W'(NUM_FU - 1)) ? '0 : last_idx + RR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) slot_q[i] <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) slot_q[i] <= slot_d[i];
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (bypass scenario only when CDB_BYPASS_EN is defined).
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic [4:0]   fu_done;
    logic [29:0]  fu_T_idx;
    logic [319:0] fu_result;
    logic         rollback;
    logic [4:0]   full_hazard;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_T_idx;
    logic [127:0] cdb_value;

    int checks = 0;
    int errors = 0;

    wire [5:0]  tag0 = cdb_T_idx[5:0];
    wire [5:0]  tag1 = cdb_T_idx[11:6];
    wire [63:0] val0 = cdb_value[63:0];
    wire [63:0] val1 = cdb_value[127:64];

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .fu_done     (fu_done),
        .fu_T_idx    (fu_T_idx),
        .fu_result   (fu_result),
        .rollback    (rollback),
        .full_hazard (full_hazard),
        .cdb_valid   (cdb_valid),
        .cdb_T_idx   (cdb_T_idx),
        .cdb_value   (cdb_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fu_done   = '0;
        fu_T_idx  = '0;
        fu_result = '0;
        rollback  = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [5:0] t, input logic [63:0] v);
        fu_done[i]           = 1'b1;
        fu_T_idx[i*6 +: 6]   = t;
        fu_result[i*64 +: 64] = v;
    endtask

    task automatic do_reset();
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", cdb_valid); end
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL rst_hazard got %b exp 00000", full_hazard); end
        checks++; if (cdb_T_idx !== 12'h000) begin errors++; $display("FAIL rst_tag got %h exp 000", cdb_T_idx); end
        checks++; if (cdb_value !== 128'h0) begin errors++; $display("FAIL rst_value got %h exp 0", cdb_value); end
        reset = 1'b0;
        next_cycle();
        set_fu(0, 6'd7, 64'h70);
        set_fu(1, 6'd8, 64'h80);
        set_fu(2, 6'd9, 64'h90);
        next_cycle();
        idle_inputs();
        #1;
`ifndef CDB_BYPASS_EN
        checks++; if (full_hazard !== 5'b00100) begin errors++; $display("FAIL rst_prefill_hazard got %b exp 00100", full_hazard); end
`endif
        #3;
        reset = 1'b1;
        #1;
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid got %b exp 00", cdb_valid); end
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL rst_mid_hazard got %b exp 00000", full_hazard); end
        next_cycle();
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL rst_stale_valid[%0d] got %b exp 00", n, cdb_valid); end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fu(2, 6'd5, 64'h1234);
        #1;
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_c0_valid got %b exp 00", cdb_valid); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (cdb_valid !== 2'b01) begin errors++; $display("FAIL single_c1_valid got %b exp 01", cdb_valid); end
        checks++; if (tag0 !== 6'd5) begin errors++; $display("FAIL single_c1_tag got %0d exp 5", tag0); end
        checks++; if (val0 !== 64'h1234) begin errors++; $display("FAIL single_c1_value got %h exp 1234", val0); end
        checks++; if (tag1 !== 6'd0 || val1 !== 64'h0) begin errors++; $display("FAIL single_c1_lane1 got tag %0d val %h exp 0 0", tag1, val1); end
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL single_c1_hazard got %b exp 00000", full_hazard); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL single_c2_valid got %b exp 00", cdb_valid); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 5; i++) set_fu(i, 6'(i + 1), 64'h100 + 64'(i));
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (cdb_valid !== 2'b11 || tag0 !== 6'd1 || tag1 !== 6'd2) begin errors++; $display("FAIL cont_c1_lanes got v=%b t0=%0d t1=%0d exp v=11 t0=1 t1=2", cdb_valid, tag0, tag1); end
        checks++; if (val0 !== 64'h100 || val1 !== 64'h101) begin errors++; $display("FAIL cont_c1_values got %h %h exp 100 101", val0, val1); end
        checks++; if (full_hazard !== 5'b11100) begin errors++; $display("FAIL cont_c1_hazard got %b exp 11100", full_hazard); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b11 || tag0 !== 6'd3 || tag1 !== 6'd4) begin errors++; $display("FAIL cont_c2_lanes got v=%b t0=%0d t1=%0d exp v=11 t0=3 t1=4", cdb_valid, tag0, tag1); end
        checks++; if (full_hazard !== 5'b10000) begin errors++; $display("FAIL cont_c2_hazard got %b exp 10000", full_hazard); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b01 || tag0 !== 6'd5 || val0 !== 64'h104) begin errors++; $display("FAIL cont_c3_lane0 got v=%b t0=%0d val=%h exp v=01 t0=5 val=104", cdb_valid, tag0, val0); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b00 || full_hazard !== 5'b00000) begin errors++; $display("FAIL cont_c4_idle got v=%b hz=%b exp 00 00000", cdb_valid, full_hazard); end
        // Pointer back at 0: FU0 must lead FU1.
        set_fu(1, 6'd11, 64'hB);
        set_fu(0, 6'd10, 64'hA);
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (tag0 !== 6'd10 || tag1 !== 6'd11) begin errors++; $display("FAIL cont_ptr_order got t0=%0d t1=%0d exp 10 11", tag0, tag1); end
        next_cycle();
    endtask

    task automatic test_hazard_hold();
        do_reset();
        for (int i = 0; i < 5; i++) set_fu(i, 6'(i + 1), 64'(i + 1));
        next_cycle();
        idle_inputs();
        set_fu(4, 6'd20, 64'd20);
        set_fu(0, 6'd10, 64'd10);
        #1;
        checks++; if (tag0 !== 6'd1 || tag1 !== 6'd2 || full_hazard !== 5'b11100) begin errors++; $display("FAIL hold_c1 got t0=%0d t1=%0d hz=%b exp 1 2 11100", tag0, tag1, full_hazard); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (tag0 !== 6'd3 || tag1 !== 6'd4 || full_hazard !== 5'b10001) begin errors++; $display("FAIL hold_c2 got t0=%0d t1=%0d hz=%b exp 3 4 10001", tag0, tag1, full_hazard); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b11 || tag0 !== 6'd5 || tag1 !== 6'd10) begin errors++; $display("FAIL hold_c3_wrap got v=%b t0=%0d t1=%0d exp 11 5 10", cdb_valid, tag0, tag1); end
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL hold_c3_hazard got %b exp 00000", full_hazard); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL hold_c4_idle got %b exp 00", cdb_valid); end
    endtask

    task automatic test_streaming();
        do_reset();
        set_fu(0, 6'd1, 64'h1000);
        for (int n = 1; n <= 8; n++) begin
            next_cycle();
            idle_inputs();
            if (n < 8) set_fu(0, 6'(n + 1), 64'h1000 + 64'(n));
            #1;
            checks++; if (cdb_valid !== 2'b01 || tag0 !== 6'(n) || val0 !== 64'h1000 + 64'(n - 1)) begin errors++; $display("FAIL stream[%0d] got v=%b t0=%0d val=%h exp 01 %0d %h", n, cdb_valid, tag0, val0, n, 64'h1000 + 64'(n - 1)); end
            checks++; if (full_hazard[0] !== 1'b0) begin errors++; $display("FAIL stream_hazard[%0d] got %b exp 0", n, full_hazard[0]); end
        end
        next_cycle();
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL stream_end got %b exp 00", cdb_valid); end
    endtask

    task automatic test_rollback();
        do_reset();
        set_fu(0, 6'd21, 64'h21);
        set_fu(1, 6'd22, 64'h22);
        set_fu(2, 6'd23, 64'h23);
        next_cycle();
        idle_inputs();
        rollback = 1'b1;
        set_fu(3, 6'd24, 64'h24);
        #1;
        checks++; if (cdb_valid !== 2'b00 || cdb_T_idx !== 12'h000) begin errors++; $display("FAIL rb_c1 got v=%b tags=%h exp 00 000", cdb_valid, cdb_T_idx); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL rb_c2_hazard got %b exp 00000", full_hazard); end
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL rb_c2_valid got %b exp 00", cdb_valid); end
        next_cycle();
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL rb_c3_valid got %b exp 00", cdb_valid); end
    endtask

`ifdef CDB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        set_fu(3, 6'd9, 64'h99);
        #1;
        checks++; if (cdb_valid !== 2'b01 || tag0 !== 6'd9 || val0 !== 64'h99) begin errors++; $display("FAIL byp_c0 got v=%b t0=%0d val=%h exp 01 9 99", cdb_valid, tag0, val0); end
        checks++; if (full_hazard !== 5'b00000) begin errors++; $display("FAIL byp_c0_hazard got %b exp 00000", full_hazard); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL byp_c1 got %b exp 00", cdb_valid); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
`ifdef CDB_BYPASS_EN
        test_bypass();
`else
        test_single();
        test_contention();
        test_hazard_hold();
        test_streaming();
        test_rollback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
